// File: rtl/mmu_walk_arbiter.sv
// Shares one page-table walker between the ITLB and DTLB miss paths: round-robin grant,
// single outstanding walk, superpage alignment check, timeout, and flush abort.
module mmu_walk_arbiter #(
   parameter int VLEN         = 39,
   parameter int ASID_WIDTH   = 16,
   parameter int WALK_TIMEOUT = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,

   input  logic                  itlb_miss_i,
   input  logic [VLEN-1:0]       itlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] itlb_asid_i,
   output logic                  itlb_gnt_o,
   output logic                  itlb_done_o,
   output logic                  itlb_err_o,

   input  logic                  dtlb_miss_i,
   input  logic [VLEN-1:0]       dtlb_vaddr_i,
   input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
   output logic                  dtlb_gnt_o,
   output logic                  dtlb_done_o,
   output logic                  dtlb_err_o,

   output logic                  ptw_req_o,
   output logic [VLEN-1:0]       ptw_vaddr_o,
   output logic [ASID_WIDTH-1:0] ptw_asid_o,
   input  logic                  ptw_ack_i,
   input  logic                  ptw_done_i,
   input  logic                  ptw_err_i,
   input  logic [63:0]           ptw_pte_i,
   input  logic                  ptw_is_2M_i,
   input  logic                  ptw_is_1G_i,

   output logic                  upd_valid_o,
   output logic                  upd_sel_o,
   output logic [26:0]           upd_vpn_o,
   output logic [ASID_WIDTH-1:0] upd_asid_o,
   output logic [63:0]           upd_pte_o,
   output logic                  upd_is_2M_o,
   output logic                  upd_is_1G_o,
   output logic                  busy_o
);

   localparam int CNT_W   = (WALK_TIMEOUT > 1) ? $clog2(WALK_TIMEOUT) : 1;
   localparam int TO_LAST = (WALK_TIMEOUT > 0) ? WALK_TIMEOUT - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_UPD,
      S_DRAIN
   } state_e;

   state_e                  r_state;
   state_e                  w_next;

   logic [VLEN-1:0]         r_vaddr;
   logic [ASID_WIDTH-1:0]   r_asid;
   logic                    r_sel;
   logic                    r_last_sel;
   logic [63:0]             r_pte;
   logic                    r_is_2M;
   logic                    r_is_1G;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_err_pulse;

   logic                    w_gnt;
   logic                    w_win_sel;
   logic                    w_misaligned;
   logic                    w_timeout;
   logic                    w_fault;
   logic                    w_store;
   logic                    w_done;

   // With both pending the winner is the one not served last; a lone requester always wins.
   assign w_gnt     = (r_state == S_IDLE) && (itlb_miss_i || dtlb_miss_i) && !flush_i;
   assign w_win_sel = (itlb_miss_i && dtlb_miss_i) ? ~r_last_sel : dtlb_miss_i;

   assign w_misaligned = (ptw_is_1G_i && (ptw_pte_i[27:10] != '0)) ||
                         (ptw_is_2M_i && (ptw_pte_i[18:10] != '0)) ||
                         (ptw_is_1G_i && ptw_is_2M_i);

   assign w_timeout = (WALK_TIMEOUT != 0) && (r_cnt == CNT_W'(TO_LAST));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next  = r_state;
      w_fault = 1'b0;
      w_store = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_gnt) w_next = S_REQ;
         end
         S_REQ: begin
            // An accepted request still owes a done, so a flush racing the ack must drain it.
            if (ptw_ack_i)    w_next = flush_i ? S_DRAIN : S_WAIT;
            else if (flush_i) w_next = S_IDLE;
         end
         S_WAIT: begin
            if (ptw_done_i) begin
               if (flush_i) begin
                  w_next = S_IDLE;
               end else if (ptw_err_i || w_misaligned) begin
                  w_fault = 1'b1;
                  w_next  = S_IDLE;
               end else begin
                  w_store = 1'b1;
                  w_next  = S_UPD;
               end
            end else if (flush_i) begin
               w_next = S_DRAIN;
            end else if (w_timeout) begin
               w_fault = 1'b1;
               w_next  = S_DRAIN;
            end
         end
         S_UPD:   w_next = S_IDLE;
         S_DRAIN: begin
            if (ptw_done_i) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      itlb_gnt_o  = w_gnt && !w_win_sel;
      dtlb_gnt_o  = w_gnt &&  w_win_sel;
      ptw_req_o   = (r_state == S_REQ);
      upd_valid_o = (r_state == S_UPD) && !flush_i;
      w_done      = upd_valid_o || r_err_pulse;
      itlb_done_o = w_done && !r_sel;
      dtlb_done_o = w_done &&  r_sel;
      itlb_err_o  = r_err_pulse && !r_sel;
      dtlb_err_o  = r_err_pulse &&  r_sel;
      busy_o      = (r_state != S_IDLE);
   end

   assign ptw_vaddr_o = r_vaddr;
   assign ptw_asid_o  = r_asid;
   assign upd_sel_o   = r_sel;
   assign upd_vpn_o   = r_vaddr[38:12];
   assign upd_asid_o  = r_asid;
   assign upd_pte_o   = r_pte;
   assign upd_is_2M_o = r_is_2M;
   assign upd_is_1G_o = r_is_1G;

   // Fault responses are registered so every done/err pulse lands the cycle after its cause.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vaddr     <= '0;
         r_asid      <= '0;
         r_sel       <= 1'b0;
         r_last_sel  <= 1'b1;
         r_pte       <= '0;
         r_is_2M     <= 1'b0;
         r_is_1G     <= 1'b0;
         r_cnt       <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= w_fault;
         if (w_gnt) begin
            r_vaddr    <= w_win_sel ? dtlb_vaddr_i : itlb_vaddr_i;
            r_asid     <= w_win_sel ? dtlb_asid_i  : itlb_asid_i;
            r_sel      <= w_win_sel;
            r_last_sel <= w_win_sel;
         end
         if (r_state == S_REQ)       r_cnt <= '0;
         else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
         if (w_store) begin
            r_pte   <= ptw_pte_i;
            r_is_2M <= ptw_is_2M_i;
            r_is_1G <= ptw_is_1G_i;
         end
      end
   end

endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Directed bench for mmu_walk_arbiter: arbitration order, successful and faulting walks,
// flush in every busy state, timeout, and reset mid-walk. Inputs change 1ns after posedge,
// outputs are sampled on the falling edge.
module tb_mmu_walk_arbiter;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          flush_i;
   logic          itlb_miss_i, dtlb_miss_i;
   logic [38:0]   itlb_vaddr_i, dtlb_vaddr_i;
   logic [15:0]   itlb_asid_i, dtlb_asid_i;
   logic          itlb_gnt_o, itlb_done_o, itlb_err_o;
   logic          dtlb_gnt_o, dtlb_done_o, dtlb_err_o;
   logic          ptw_req_o;
   logic [38:0]   ptw_vaddr_o;
   logic [15:0]   ptw_asid_o;
   logic          ptw_ack_i, ptw_done_i, ptw_err_i;
   logic [63:0]   ptw_pte_i;
   logic          ptw_is_2M_i, ptw_is_1G_i;
   logic          upd_valid_o, upd_sel_o;
   logic [26:0]   upd_vpn_o;
   logic [15:0]   upd_asid_o;
   logic [63:0]   upd_pte_o;
   logic          upd_is_2M_o, upd_is_1G_o;
   logic          busy_o;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [63:0] pte;
      logic        m2;
      logic        g1;
      logic        err;
      logic        fault;
   } leaf_t;

   mmu_walk_arbiter #(.VLEN(39), .ASID_WIDTH(16), .WALK_TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .itlb_miss_i(itlb_miss_i), .itlb_vaddr_i(itlb_vaddr_i), .itlb_asid_i(itlb_asid_i),
      .itlb_gnt_o(itlb_gnt_o), .itlb_done_o(itlb_done_o), .itlb_err_o(itlb_err_o),
      .dtlb_miss_i(dtlb_miss_i), .dtlb_vaddr_i(dtlb_vaddr_i), .dtlb_asid_i(dtlb_asid_i),
      .dtlb_gnt_o(dtlb_gnt_o), .dtlb_done_o(dtlb_done_o), .dtlb_err_o(dtlb_err_o),
      .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o), .ptw_asid_o(ptw_asid_o),
      .ptw_ack_i(ptw_ack_i), .ptw_done_i(ptw_done_i), .ptw_err_i(ptw_err_i),
      .ptw_pte_i(ptw_pte_i), .ptw_is_2M_i(ptw_is_2M_i), .ptw_is_1G_i(ptw_is_1G_i),
      .upd_valid_o(upd_valid_o), .upd_sel_o(upd_sel_o), .upd_vpn_o(upd_vpn_o),
      .upd_asid_o(upd_asid_o), .upd_pte_o(upd_pte_o), .upd_is_2M_o(upd_is_2M_o),
      .upd_is_1G_o(upd_is_1G_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Raise the given misses in IDLE and check which side is granted. The DTLB presents
   // va + 0x1000 and asid + 1 so the latched fields reveal the winner.
   task automatic miss(input logic im, input logic dm, input logic [38:0] va,
                       input logic [15:0] asid, input logic exp_sel, input string tag);
      itlb_miss_i  = im;
      dtlb_miss_i  = dm;
      itlb_vaddr_i = va;
      dtlb_vaddr_i = va + 39'h1000;
      itlb_asid_i  = asid;
      dtlb_asid_i  = asid + 16'd1;
      @(negedge clk_i);
      check({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
      check({tag, "_itlb_gnt"}, 64'(itlb_gnt_o), 64'(!exp_sel));
      check({tag, "_dtlb_gnt"}, 64'(dtlb_gnt_o), 64'(exp_sel));
      step();
      itlb_miss_i = 1'b0;
      dtlb_miss_i = 1'b0;
   endtask

   task automatic req_cycle(input logic [38:0] exp_va, input logic [15:0] exp_asid,
                            input string tag);
      ptw_ack_i = 1'b1;
      @(negedge clk_i);
      check({tag, "_req"}, 64'(ptw_req_o), 64'd1);
      check({tag, "_req_va"}, 64'(ptw_vaddr_o), 64'(exp_va));
      check({tag, "_req_asid"}, 64'(ptw_asid_o), 64'(exp_asid));
      step();
      ptw_ack_i = 1'b0;
   endtask

   task automatic done_cycle(input logic [63:0] pte, input logic m2, input logic g1,
                             input logic err, input string tag);
      ptw_done_i  = 1'b1;
      ptw_pte_i   = pte;
      ptw_is_2M_i = m2;
      ptw_is_1G_i = g1;
      ptw_err_i   = err;
      @(negedge clk_i);
      check({tag, "_done_busy"}, 64'(busy_o), 64'd1);
      check({tag, "_done_early"}, 64'({itlb_done_o, dtlb_done_o, upd_valid_o}), 64'd0);
      step();
      ptw_done_i  = 1'b0;
      ptw_err_i   = 1'b0;
      ptw_is_2M_i = 1'b0;
      ptw_is_1G_i = 1'b0;
      ptw_pte_i   = '0;
   endtask

   task automatic expect_upd(input logic sel, input logic [26:0] vpn, input logic [15:0] asid,
                             input logic [63:0] pte, input logic m2, input logic g1,
                             input string tag);
      @(negedge clk_i);
      check({tag, "_upd_valid"}, 64'(upd_valid_o), 64'd1);
      check({tag, "_upd_sel"}, 64'(upd_sel_o), 64'(sel));
      check({tag, "_upd_vpn"}, 64'(upd_vpn_o), 64'(vpn));
      check({tag, "_upd_asid"}, 64'(upd_asid_o), 64'(asid));
      check({tag, "_upd_pte"}, upd_pte_o, pte);
      check({tag, "_upd_flags"}, 64'({upd_is_2M_o, upd_is_1G_o}), 64'({m2, g1}));
      check({tag, "_done_pair"}, 64'({itlb_done_o, dtlb_done_o}), 64'({!sel, sel}));
      check({tag, "_err_pair"}, 64'({itlb_err_o, dtlb_err_o}), 64'd0);
      step();
   endtask

   task automatic expect_err(input logic sel, input logic exp_busy, input string tag);
      @(negedge clk_i);
      check({tag, "_err_upd"}, 64'(upd_valid_o), 64'd0);
      check({tag, "_err_done"}, 64'({itlb_done_o, dtlb_done_o}), 64'({!sel, sel}));
      check({tag, "_err_err"}, 64'({itlb_err_o, dtlb_err_o}), 64'({!sel, sel}));
      check({tag, "_err_busy"}, 64'(busy_o), 64'(exp_busy));
      step();
   endtask

   task automatic expect_quiet(input logic exp_busy, input string tag);
      @(negedge clk_i);
      check({tag, "_quiet"},
            64'({itlb_done_o, dtlb_done_o, itlb_err_o, dtlb_err_o, upd_valid_o}), 64'd0);
      check({tag, "_busy"}, 64'(busy_o), 64'(exp_busy));
      step();
   endtask

   leaf_t leaves [6] = '{
      '{pte: 64'h0000_0000_0000_04CF, m2: 1'b0, g1: 1'b1, err: 1'b0, fault: 1'b1},
      '{pte: 64'h0000_0000_2000_00CF, m2: 1'b0, g1: 1'b0, err: 1'b1, fault: 1'b1},
      '{pte: 64'h0000_0000_0008_00CF, m2: 1'b1, g1: 1'b0, err: 1'b0, fault: 1'b0},
      '{pte: 64'h0000_0000_0004_00CF, m2: 1'b1, g1: 1'b0, err: 1'b0, fault: 1'b1},
      '{pte: 64'h0000_0000_1000_00CF, m2: 1'b0, g1: 1'b1, err: 1'b0, fault: 1'b0},
      '{pte: 64'h0000_0000_1000_00CF, m2: 1'b1, g1: 1'b1, err: 1'b0, fault: 1'b1}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0;
      flush_i = 1'b0;
      itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0;
      itlb_vaddr_i = '0;  dtlb_vaddr_i = '0;
      itlb_asid_i = '0;   dtlb_asid_i = '0;
      ptw_ack_i = 1'b0; ptw_done_i = 1'b0; ptw_err_i = 1'b0;
      ptw_pte_i = '0; ptw_is_2M_i = 1'b0; ptw_is_1G_i = 1'b0;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_req", 64'(ptw_req_o), 64'd0);
      check("rst_upd", 64'({upd_valid_o, upd_sel_o, upd_is_2M_o, upd_is_1G_o}), 64'd0);
      check("rst_vpn", 64'(upd_vpn_o), 64'd0);
      check("rst_pte", upd_pte_o, 64'd0);
      check("rst_done", 64'({itlb_done_o, dtlb_done_o, itlb_err_o, dtlb_err_o}), 64'd0);
      step();
      rst_ni = 1'b1;
      step();

      // Round robin from reset: ITLB, then DTLB, then ITLB again.
      for (int i = 0; i < 3; i++) begin
         logic s;
         s = (i == 1);
         miss(1'b1, 1'b1, 39'h12_3456_7000, 16'd7, s, "arb");
         req_cycle(s ? 39'h12_3456_8000 : 39'h12_3456_7000, s ? 16'd8 : 16'd7, "arb");
         done_cycle(64'h0000_0000_1234_50CF, 1'b0, 1'b0, 1'b0, "arb");
         expect_upd(s, s ? 27'h1234568 : 27'h1234567, s ? 16'd8 : 16'd7,
                    64'h0000_0000_1234_50CF, 1'b0, 1'b0, "arb");
      end

      // Lone ITLB miss wins although rotation would now favour the DTLB.
      miss(1'b1, 1'b0, 39'h40_0000_1000, 16'd3, 1'b0, "itlb");
      req_cycle(39'h40_0000_1000, 16'd3, "itlb");
      repeat (3) expect_quiet(1'b1, "itlb_wait");
      done_cycle(64'h0000_0000_2000_00CF, 1'b0, 1'b0, 1'b0, "itlb");
      expect_upd(1'b0, 27'h4000001, 16'd3, 64'h0000_0000_2000_00CF, 1'b0, 1'b0, "itlb");
      expect_quiet(1'b0, "itlb_after");

      // Leaf alignment and walker faults on the DTLB side.
      for (int i = 0; i < 6; i++) begin
         miss(1'b0, 1'b1, 39'h00_0020_0000, 16'd9, 1'b1, "leaf");
         req_cycle(39'h00_0020_1000, 16'd10, "leaf");
         done_cycle(leaves[i].pte, leaves[i].m2, leaves[i].g1, leaves[i].err, "leaf");
         if (leaves[i].fault) expect_err(1'b1, 1'b0, $sformatf("leaf%0d", i));
         else expect_upd(1'b1, 27'h000201, 16'd10, leaves[i].pte, leaves[i].m2,
                         leaves[i].g1, $sformatf("leaf%0d", i));
      end

      // Flush two cycles into WAIT: drain until the walker's done, flush ignored while draining.
      miss(1'b1, 1'b0, 39'h01_0000_0000, 16'd4, 1'b0, "fw");
      req_cycle(39'h01_0000_0000, 16'd4, "fw");
      repeat (2) expect_quiet(1'b1, "fw_wait");
      flush_i = 1'b1;
      expect_quiet(1'b1, "fw_flush");
      expect_quiet(1'b1, "fw_drain0");
      flush_i = 1'b0;
      expect_quiet(1'b1, "fw_drain1");
      done_cycle(64'h0000_0000_0000_00CF, 1'b0, 1'b0, 1'b0, "fw");
      miss(1'b1, 1'b0, 39'h01_0000_2000, 16'd4, 1'b0, "fw_next");
      req_cycle(39'h01_0000_2000, 16'd4, "fw_next");
      done_cycle(64'h0000_0000_0000_10CF, 1'b0, 1'b0, 1'b0, "fw_next");
      expect_upd(1'b0, 27'h0100002, 16'd4, 64'h0000_0000_0000_10CF, 1'b0, 1'b0, "fw_next");

      // Timeout of 8: error pulse 8 cycles after entering WAIT, then a silent drain.
      miss(1'b0, 1'b1, 39'h02_0000_0000, 16'd1, 1'b1, "to");
      req_cycle(39'h02_0000_1000, 16'd2, "to");
      repeat (8) expect_quiet(1'b1, "to_wait");
      expect_err(1'b1, 1'b1, "to");
      expect_quiet(1'b1, "to_drain");
      done_cycle(64'h0000_0000_0000_00CF, 1'b0, 1'b0, 1'b0, "to_late");
      expect_quiet(1'b0, "to_idle");

      // Flush blocks a grant in IDLE, then flush in REQ returns to IDLE silently.
      itlb_miss_i = 1'b1;
      flush_i = 1'b1;
      @(negedge clk_i);
      check("fi_gnt", 64'({itlb_gnt_o, dtlb_gnt_o}), 64'd0);
      step();
      flush_i = 1'b0;
      miss(1'b1, 1'b0, 39'h03_0000_0000, 16'd5, 1'b0, "fr");
      flush_i = 1'b1;
      @(negedge clk_i);
      check("fr_req", 64'(ptw_req_o), 64'd1);
      step();
      flush_i = 1'b0;
      expect_quiet(1'b0, "fr_idle");

      // Flush in UPD suppresses the write and the done pulse.
      miss(1'b1, 1'b0, 39'h03_0000_4000, 16'd5, 1'b0, "fu");
      req_cycle(39'h03_0000_4000, 16'd5, "fu");
      done_cycle(64'h0000_0000_0000_20CF, 1'b0, 1'b0, 1'b0, "fu");
      flush_i = 1'b1;
      expect_quiet(1'b1, "fu_upd");
      flush_i = 1'b0;
      expect_quiet(1'b0, "fu_idle");

      // Flush together with done in WAIT discards the result and goes straight to IDLE.
      miss(1'b0, 1'b1, 39'h04_0000_0000, 16'd6, 1'b1, "fd");
      req_cycle(39'h04_0000_1000, 16'd7, "fd");
      flush_i = 1'b1;
      done_cycle(64'h0000_0000_0000_30CF, 1'b0, 1'b0, 1'b0, "fd");
      flush_i = 1'b0;
      expect_quiet(1'b0, "fd_idle");

      // Asynchronous reset mid-walk.
      miss(1'b1, 1'b0, 39'h05_0000_0000, 16'd2, 1'b0, "rw");
      req_cycle(39'h05_0000_0000, 16'd2, "rw");
      rst_ni = 1'b0;
      #1;
      check("rw_busy", 64'(busy_o), 64'd0);
      check("rw_req", 64'(ptw_req_o), 64'd0);
      step();
      rst_ni = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
